// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - LEGv8 R/I/D/B/CB encoder writing consecutive words into instruction memory
// Optional: IMEM_LOADER_RANGE_CHECK_EN rejects immediates that do not fit their field.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module imem_loader #(
    parameter int SIZE = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 fmt,
    input  logic [10:0]                opcode,
    input  logic [4:0]                 rd,
    input  logic [4:0]                 rn,
    input  logic [4:0]                 rm,
    input  logic [5:0]                 shamt,
    input  logic [`WORD-1:0]           imm,
    output logic                       imem_we,
    output logic [`WORD-1:0]           imem_addr,
    output logic [`INSTR_LEN-1:0]      imem_wdata,
    output logic [$clog2(SIZE+1)-1:0]  count,
    output logic                       full,
    output logic                       err
);
    localparam int CW = $clog2(SIZE+1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ENC   = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] FULL  = 2'd3;

    logic [1:0]            state;
    logic [2:0]            fmt_q;
    logic [10:0]           opcode_q;
    logic [4:0]            rd_q, rn_q, rm_q;
    logic [5:0]            shamt_q;
    logic [`WORD-1:0]      imm_q;
    logic [`INSTR_LEN-1:0] enc_word;
    logic                  fmt_bad;
    logic                  range_bad;
    logic [CW-1:0]         next_count;

    assign in_ready   = (state == IDLE);
    assign imem_we    = (state == WRITE);
    assign full       = (state == FULL);
    assign next_count = count + 1'b1;

    always_comb begin
        enc_word = '0;
        fmt_bad  = 1'b0;
        case (fmt_q)
            3'd0:    enc_word = {opcode_q, rm_q, shamt_q, rn_q, rd_q};
            3'd1:    enc_word = {opcode_q[10:1], imm_q[11:0], rn_q, rd_q};
            3'd2:    enc_word = {opcode_q, imm_q[8:0], 2'b00, rn_q, rd_q};
            3'd3:    enc_word = {opcode_q[10:5], imm_q[25:0]};
            3'd4:    enc_word = {opcode_q[10:3], imm_q[18:0], rd_q};
            default: fmt_bad  = 1'b1;
        endcase
    end

`ifdef IMEM_LOADER_RANGE_CHECK_EN
    // A signed field fits when every bit above its sign bit copies the sign bit.
    always_comb begin
        range_bad = 1'b0;
        case (fmt_q)
            3'd1:    range_bad = |imm_q[`WORD-1:12];
            3'd2:    range_bad = imm_q[`WORD-1:8]  != {(`WORD-8){imm_q[8]}};
            3'd3:    range_bad = imm_q[`WORD-1:25] != {(`WORD-25){imm_q[25]}};
            3'd4:    range_bad = imm_q[`WORD-1:18] != {(`WORD-18){imm_q[18]}};
            default: range_bad = 1'b0;
        endcase
    end
`else
    logic unused_imm;
    assign unused_imm = ^imm_q[`WORD-1:26];
    assign range_bad  = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fmt_q      <= '0;
            opcode_q   <= '0;
            rd_q       <= '0;
            rn_q       <= '0;
            rm_q       <= '0;
            shamt_q    <= '0;
            imm_q      <= '0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            count      <= '0;
            err        <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            imem_addr <= '0;
            count     <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (in_valid) begin
                    fmt_q    <= fmt;
                    opcode_q <= opcode;
                    rd_q     <= rd;
                    rn_q     <= rn;
                    rm_q     <= rm;
                    shamt_q  <= shamt;
                    imm_q    <= imm;
                    state    <= ENC;
                end
                ENC: if (fmt_bad || range_bad) begin
                    err   <= 1'b1;
                    state <= IDLE;
                end else begin
                    imem_wdata <= enc_word;
                    state      <= WRITE;
                end
                WRITE: begin
                    imem_addr <= imem_addr + `WORD'(4);
                    count     <= next_count;
                    state     <= (next_count == SIZE[CW-1:0]) ? FULL : IDLE;
                end
                default: state <= FULL;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader with an arithmetic encoding model
module tb_imem_loader;
    localparam int SIZE = 16;

    logic        clk = 1'b0;
    logic        reset, clear, in_valid, in_ready;
    logic [2:0]  fmt;
    logic [10:0] opcode;
    logic [4:0]  rd, rn, rm;
    logic [5:0]  shamt;
    logic [63:0] imm;
    logic        imem_we;
    logic [63:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [4:0]  count;
    logic        full, err;

    imem_loader #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rn(rn), .rm(rm), .shamt(shamt), .imm(imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [63:0] addr;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   m_addr = 0;
    int   m_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, want);
        end
    endtask

    // Non-negative residue of v modulo 2^bits: the field's bit pattern as a number.
    function automatic longint fld(input longint v, input int bits);
        longint m;
        m = longint'(1) << bits;
        return ((v % m) + m) % m;
    endfunction

    function automatic logic [31:0] model_word(input longint f, input longint opc, input longint r_d,
                                               input longint r_n, input longint r_m, input longint sh,
                                               input longint im);
        longint w;
        case (f)
            0:       w = opc * (longint'(1) << 21) + r_m * 65536 + sh * 1024 + r_n * 32 + r_d;
            1:       w = (opc / 2) * (longint'(1) << 22) + fld(im, 12) * 1024 + r_n * 32 + r_d;
            2:       w = opc * (longint'(1) << 21) + fld(im, 9) * 4096 + r_n * 32 + r_d;
            3:       w = (opc / 32) * (longint'(1) << 26) + fld(im, 26);
            default: w = (opc / 8) * (longint'(1) << 24) + fld(im, 19) * 32 + r_d;
        endcase
        return w[31:0];
    endfunction

    function automatic bit model_reject(input int f, input longint im);
        if (f > 4) return 1'b1;
`ifdef IMEM_LOADER_RANGE_CHECK_EN
        case (f)
            1: return (im < 0) || (im > 4095);
            2: return (im < -256) || (im > 255);
            3: return (im < -(longint'(1) << 25)) || (im > (longint'(1) << 25) - 1);
            4: return (im < -(longint'(1) << 18)) || (im > (longint'(1) << 18) - 1);
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en && (imem_we === 1'b1 || err === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output we=%0b err=%0b addr=%0h required=none", imem_we, err, imem_addr);
            end else begin
                e = sb.pop_front();
                chk("out_is_err", {63'd0, err}, {63'd0, e.is_err});
                chk("out_we", {63'd0, imem_we}, {63'd0, !e.is_err});
                if (!e.is_err) begin
                    chk("imem_addr", imem_addr, e.addr);
                    chk("imem_wdata", {32'd0, imem_wdata}, {32'd0, e.word});
                end
            end
        end
    end

    task automatic send(input int f, input int opc, input int r_d, input int r_n, input int r_m,
                        input int sh, input longint im, input bit push);
        bit rej;
        int n;
        fmt = f[2:0]; opcode = opc[10:0]; rd = r_d[4:0]; rn = r_n[4:0];
        rm = r_m[4:0]; shamt = sh[5:0]; imm = im; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (!in_ready) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        rej = model_reject(f, im);
        if (push) begin
            sb.push_back('{rej, 64'(m_addr), model_word(f, opc, r_d, r_n, r_m, sh, im)});
            if (!rej) begin m_addr += 4; m_count++; end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (!push) return;
        if (m_count == SIZE) begin
            repeat (3) @(negedge clk);
        end else begin
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 10) begin n++; @(negedge clk); end
            chk("ready_low_cycles", 64'(n), rej ? 64'd1 : 64'd2);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        chk("count", {59'd0, count}, 64'(m_count));
        chk("full", {63'd0, full}, {63'd0, m_count == SIZE});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        m_addr = 0;
        m_count = 0;
        @(negedge clk);
        chk("clear_in_ready", {63'd0, in_ready}, 64'd1);
        chk("clear_count", {59'd0, count}, 64'd0);
        chk("clear_addr", imem_addr, 64'd0);
    endtask

    longint imm_pool[16] = '{0, 4095, 4096, -1, -256, 255, 256, -257,
                             33554431, 33554432, -33554432, -33554433,
                             262143, 262144, -262144, -262145};

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int f;
        longint im;
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0;
        fmt = '0; opcode = '0; rd = '0; rn = '0; rm = '0; shamt = '0; imm = '0;
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_we", {63'd0, imem_we}, 64'd0);
        chk("rst_addr", imem_addr, 64'd0);
        chk("rst_wdata", {32'd0, imem_wdata}, 64'd0);
        chk("rst_count", {59'd0, count}, 64'd0);
        chk("rst_full", {63'd0, full}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;

        send(2, 11'b11111000010, 9, 22, 0, 0, 64, 1'b1);
        drain();
        chk("d_vector_word", {32'd0, imem_wdata}, 64'hF84402C9);

        send(0, 11'b10001011000, 10, 19, 9, 0, 0, 1'b1);
        chk("r_vector_word", {32'd0, imem_wdata}, 64'h8B09026A);
        send(4, 11'b10110100000, 11, 0, 0, 0, -5, 1'b1);
        chk("cb_vector_word", {32'd0, imem_wdata}, 64'hB4FFFF6B);
        drain();

        send(2, 11'b11111000000, 1, 2, 0, 0, 256, 1'b1);
        send(6, 11'b10001011000, 1, 2, 3, 0, 0, 1'b1);
        drain();

        // Asynchronous reset landing in the WRITE cycle.
        mon_en = 1'b0;
        send(0, 11'b10001011000, 3, 4, 5, 0, 0, 1'b0);
        @(posedge clk);
        #1 chk("we_before_reset", {63'd0, imem_we}, 64'd1);
        reset = 1'b0;
        #1 chk("we_in_reset", {63'd0, imem_we}, 64'd0);
        chk("count_in_reset", {59'd0, count}, 64'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {63'd0, in_ready}, 64'd1);
        chk("we_after_reset", {63'd0, imem_we}, 64'd0);
        m_addr = 0;
        m_count = 0;
        mon_en = 1'b1;

        while (m_count < SIZE)
            send($urandom_range(0, 4), $urandom_range(0, 2047), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 63),
                 longint'($urandom_range(0, 255)), 1'b1);
        drain();
        chk("full_in_ready", {63'd0, in_ready}, 64'd0);
        chk("full_addr", imem_addr, 64'd64);
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        chk("held_17th_count", {59'd0, count}, 64'(SIZE));
        chk("held_17th_full", {63'd0, full}, 64'd1);

        do_clear();
        send(2, 11'b11111000010, 9, 22, 0, 0, 64, 1'b1);
        drain();

        for (int i = 0; i < 80; i++) begin
            if (m_count == SIZE) begin
                drain();
                do_clear();
            end
            f = $urandom_range(0, 5);
            if (f == 5) f = $urandom_range(5, 7);
            if ($urandom_range(0, 1) == 1) im = imm_pool[$urandom_range(0, 15)];
            else im = longint'($signed($urandom()));
            send(f, $urandom_range(0, 2047), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 63), im, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader: the writing end of the instruction memory that `iFetch` reads. It accepts symbolic LEGv8 instruction descriptions over a valid/ready handshake and encodes each into a 32-bit word in R, I, D, B or CB format. It then writes the word to the instruction-memory write port at consecutive word addresses starting at 0. Benches and boot logic use it to program programs without hand-assembled hex.

## Interface
- `SIZE`, 16, instruction-memory depth in words; matches `iFetch` `SIZE`.
- `clk`  in  1  clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous restart to address 0.
- `in_valid`  in  1  instruction description valid.
- `in_ready`  out  1  loader can accept a description.
- `fmt`  in  3  format: 0 R, 1 I, 2 D, 3 B, 4 CB, 5-7 illegal.
- `opcode`  in  11  left-aligned opcode.
- `rd`  in  5  Rd/Rt.
- `rn`  in  5  Rn.
- `rm`  in  5  Rm.
- `shamt`  in  6  R-format shift amount.
- `imm`  in  `WORD  signed immediate, in bytes for I/D and in words for B/CB.
- `imem_we`  out  1  write strobe, one cycle per word.
- `imem_addr`  out  `WORD  byte address of the write.
- `imem_wdata`  out  `INSTR_LEN  encoded word.
- `count`  out  $clog2(SIZE+1)  words written.
- `full`  out  1  count == SIZE.
- `err`  out  1  one-cycle pulse on a rejected description.

## Operation
- FSM states: IDLE, ENC, WRITE, FULL. `in_ready` = (state == IDLE).
- IDLE: on `in_valid && in_ready`, all fields are registered and the FSM goes to ENC.
- ENC: encodes the registered fields combinationally.
  - Illegal fmt: pulse `err` and return to IDLE.
  - Range failure (see Configuration): pulse `err` and return to IDLE.
  - Otherwise: register `imem_wdata` and go to WRITE.
- WRITE: `imem_we`=1 for exactly one cycle.
  - At the closing edge, `imem_addr` += 4 and `count` += 1.
  - Next state is FULL if the new count == SIZE, else IDLE.
- FULL: `full`=1 and `in_ready`=0. Only `clear` or `reset` leaves this state.
- Encodings:
  - R: opcode[10:0] to [31:21], rm to [20:16], shamt to [15:10], rn to [9:5], rd to [4:0].
  - I: opcode[10:1] to [31:22], imm[11:0] (unsigned) to [21:10], rn, rd.
  - D: opcode[10:0] to [31:21], imm[8:0] (signed) to [20:12], 2'b00 to [11:10], rn, rd.
  - B: opcode[10:5] to [31:26], imm[25:0] (signed) to [25:0].
  - CB: opcode[10:3] to [31:24], imm[18:0] (signed) to [23:5], rd to [4:0].
- Unused opcode LSBs and unused register fields are ignored.
- `clear` has priority over the handshake in every state.
  - Next state is IDLE; `imem_addr`=0 and `count`=0.
  - A pending WRITE is aborted: `imem_we`=0 from the next cycle.
  - Memory contents are untouched.

## Timing
- Reset values: `in_ready`=1 (IDLE), `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `count`=0, `full`=0, `err`=0.
- Handshake accepted on edge k:
  - ENC occupies cycle k..k+1.
  - `imem_we` is high for cycle k+1..k+2, and memory captures on edge k+2.
  - `err`, when raised, is high for cycle k+1..k+2 instead.
- Throughput: one word per 3 cycles. `in_ready` is low for 2 cycles after each accept.
- `imem_addr` and `imem_wdata` are stable for the whole cycle in which `imem_we`=1.
- `full` rises in the same cycle that `count` reaches SIZE.
- Asynchronous reset asserted mid-WRITE: `imem_we` drops immediately and no further write occurs.

## Configuration
- `IMEM_LOADER_RANGE_CHECK_EN` defined:
  - Rejects any immediate that does not fit its field: I 0..4095; D -256..255; B -2^25..2^25-1; CB -2^18..2^18-1.
  - A rejected description pulses `err`, with no write and no address or count change.
- Not defined: immediates are silently truncated to the field width, and only illegal fmt raises `err`.

## Test plan
- D, opcode 11111000010, rn 22, rd 9, imm 64 → `imem_we` for one cycle at addr 0 with `imem_wdata`=F84402C9, then `count`=1.
- Back-to-back:
  - R, opcode 10001011000, rm 9, rn 19, rd 10 → 8B09026A at addr 4.
  - CB, opcode 10110100000, rd 11, imm -5 → B4FFFF6B at addr 8.
  - Check `in_ready` low exactly 2 cycles per accept.
- 16 writes with SIZE=16:
  - `full`=1, `in_ready`=0, last write at addr 60.
  - A held 17th `in_valid` produces no write.
- D imm 256:
  - With the macro: `err` pulse, no `imem_we`, `count` unchanged.
  - Without the macro: word written with [20:12]=0x100.
- fmt=6 → `err` pulse, no write. Reset asserted during WRITE → `imem_we`=0 immediately, `count`=0 and `in_ready`=1 after release.
- `clear` while FULL → `in_ready`=1 next cycle, and the next description is written at addr 0 with `count`=1.
